// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU ALU sequencer: opcodes, FSM states, instruction layout.
package mcpu_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Instruction is {opcode, dst, src1, src2}; slot N starts at bit N*REG_ADDR.
  localparam int unsigned FLD_SRC2 = 0;
  localparam int unsigned FLD_SRC1 = 1;
  localparam int unsigned FLD_DST  = 2;
  localparam int unsigned FLD_OP   = 3;

endpackage

// File: rtl/mcpu_alu_sequencer_if.sv
// Instruction, load, ALU and result signals of the MCPU ALU sequencer.
interface mcpu_alu_sequencer_if #(
  parameter int unsigned CMD_SIZE  = 2,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned REG_ADDR  = 2
);
  logic                            instr_valid;
  logic                            instr_ready;
  logic [CMD_SIZE+3*REG_ADDR-1:0]  instr;
  logic                            load_en;
  logic [REG_ADDR-1:0]             load_addr;
  logic [WORD_SIZE-1:0]            load_data;
  logic                            flag_clr;
  logic [CMD_SIZE-1:0]             alu_opcode;
  logic [WORD_SIZE-1:0]            alu_r1;
  logic [WORD_SIZE-1:0]            alu_r2;
  logic [2*WORD_SIZE-1:0]          alu_out;
  logic                            alu_overflow;
  logic                            res_valid;
  logic [WORD_SIZE-1:0]            res_data;
  logic [REG_ADDR-1:0]             res_dst;
  logic                            ovf_flag;

  modport master (
    output instr_valid, instr, load_en, load_addr, load_data, flag_clr, alu_out, alu_overflow,
    input  instr_ready, alu_opcode, alu_r1, alu_r2, res_valid, res_data, res_dst, ovf_flag
  );

  modport slave (
    input  instr_valid, instr, load_en, load_addr, load_data, flag_clr, alu_out, alu_overflow,
    output instr_ready, alu_opcode, alu_r1, alu_r2, res_valid, res_data, res_dst, ovf_flag
  );
endinterface

// File: rtl/mcpu_regfile.sv
// Register file: two combinational read ports, writeback port taking priority over load port.
module mcpu_regfile #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned REG_ADDR  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_ADDR-1:0]  ra1_i,
  input  logic [REG_ADDR-1:0]  ra2_i,
  output logic [WORD_SIZE-1:0] rd1_o,
  output logic [WORD_SIZE-1:0] rd2_o,
  input  logic                 wb_en_i,
  input  logic [REG_ADDR-1:0]  wb_addr_i,
  input  logic [WORD_SIZE-1:0] wb_data_i,
  input  logic                 ld_en_i,
  input  logic [REG_ADDR-1:0]  ld_addr_i,
  input  logic [WORD_SIZE-1:0] ld_data_i
);
  localparam int unsigned DEPTH = 2**REG_ADDR;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wb_en_i && wb_addr_i == REG_ADDR'(i))      mem_q[i] <= wb_data_i;
        else if (ld_en_i && ld_addr_i == REG_ADDR'(i)) mem_q[i] <= ld_data_i;
      end
    end
  end

  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
endmodule

// File: rtl/mcpu_alu_sequencer.sv
// Issue/writeback sequencer wrapping a combinational MCPU_Alu: IDLE -> EXEC -> WB per instruction.
// Define MCPU_SEQ_STICKY_OVF_EN for a sticky overflow flag cleared by flag_clr.
module mcpu_alu_sequencer
  import mcpu_pkg::*;
#(
  parameter int unsigned CMD_SIZE  = 2,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned REG_ADDR  = 2
) (
  input logic                 clk,
  input logic                 reset,
  mcpu_alu_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic   accept, capture, wb;

  logic [CMD_SIZE-1:0]  opcode_q;
  logic [WORD_SIZE-1:0] r1_q, r2_q, res_lo_q, res_data_q;
  logic [REG_ADDR-1:0]  dst_q, res_dst_q;
  logic                 res_ovf_q, res_valid_q, ovf_q, ovf_d;

  logic [CMD_SIZE-1:0]  in_op;
  logic [REG_ADDR-1:0]  in_dst, in_src1, in_src2;
  logic [WORD_SIZE-1:0] rd1, rd2;
  logic                 is_add;

  assign in_op   = bus.instr[FLD_OP*REG_ADDR +: CMD_SIZE];
  assign in_dst  = bus.instr[FLD_DST*REG_ADDR +: REG_ADDR];
  assign in_src1 = bus.instr[FLD_SRC1*REG_ADDR +: REG_ADDR];
  assign in_src2 = bus.instr[FLD_SRC2*REG_ADDR +: REG_ADDR];
  assign is_add  = (opcode_q == CMD_SIZE'(OP_ADD));

  mcpu_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .REG_ADDR  (REG_ADDR)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (reset),
    .ra1_i     (in_src1),
    .ra2_i     (in_src2),
    .rd1_o     (rd1),
    .rd2_o     (rd2),
    .wb_en_i   (wb),
    .wb_addr_i (dst_q),
    .wb_data_i (res_lo_q),
    .ld_en_i   (bus.load_en),
    .ld_addr_i (bus.load_addr),
    .ld_data_i (bus.load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    wb      = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.instr_valid) begin
        accept  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        wb      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MCPU_SEQ_STICKY_OVF_EN
  // A set in WB outranks a same-cycle clear.
  always_comb begin
    ovf_d = bus.flag_clr ? 1'b0 : ovf_q;
    if (wb) ovf_d = ovf_d | (is_add & res_ovf_q);
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = bus.flag_clr;

  always_comb begin
    ovf_d = ovf_q;
    if (wb) ovf_d = is_add & res_ovf_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q    <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      dst_q       <= '0;
      res_lo_q    <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= in_op;
        r1_q     <= rd1;
        r2_q     <= rd2;
        dst_q    <= in_dst;
      end
      if (capture) begin
        res_lo_q  <= bus.alu_out[WORD_SIZE-1:0];
        res_ovf_q <= bus.alu_overflow;
      end
      res_valid_q <= wb;
      if (wb) begin
        res_data_q <= res_lo_q;
        res_dst_q  <= dst_q;
      end
      ovf_q <= ovf_d;
    end
  end

  logic unused_alu_hi;
  assign unused_alu_hi = ^bus.alu_out[2*WORD_SIZE-1:WORD_SIZE];

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_r1      = r1_q;
  assign bus.alu_r2      = r2_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_dst     = res_dst_q;
  assign bus.ovf_flag    = ovf_q;
endmodule
